// File: rtl/plot_pkg.sv
// Shared types and defaults for the two-player box plotter.
// Player ids double as the rr_arbiter2 grant encoding.
package plot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam int BOX_W_DEF    = 4;
  localparam int BOX_H_DEF    = 4;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int C_W_DEF      = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_grant only moves when en_i accepts the grant.
// Combinational grant, one register of history.
module rr_arbiter2
  import plot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       vld_o
);

  logic last_q, last_d;

  always_comb begin
    vld_o = |req_i;
    if (req_i[0] && req_i[1]) begin
      gnt_o = ~last_q;
    end else if (req_i[0]) begin
      gnt_o = P1;
    end else begin
      gnt_o = P2;
    end
    last_d = en_i ? gnt_o : last_q;
  end

  // P2 as history makes P1 win the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= P2;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA plot port between two players: round-robin grant, BOX_W x BOX_H sweep, one-cycle ack.
// SCREEN_CLEAR_EN adds a full-screen colour-0 sweep after reset before any grant.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int BOX_W    = BOX_W_DEF,
  parameter int BOX_H    = BOX_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int C_W      = C_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_p1,
  input  logic [X_W-1:0] x_p1,
  input  logic [Y_W-1:0] y_p1,
  input  logic [C_W-1:0] colour_p1,
  input  logic           req_p2,
  input  logic [X_W-1:0] x_p2,
  input  logic [Y_W-1:0] y_p2,
  input  logic [C_W-1:0] colour_p2,
  output logic           ack_p1,
  output logic           ack_p2,
  output logic           busy,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  localparam int CXW = cnt_w(BOX_W);
  localparam int CYW = cnt_w(BOX_H);

  state_t         state_q, state_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [X_W-1:0] bx_q, bx_d;
  logic [Y_W-1:0] by_q, by_d;
  logic [C_W-1:0] col_q, col_d;
  logic           gnt_q, gnt_d;
  logic           arb_gnt, arb_vld, arb_en;

`ifdef SCREEN_CLEAR_EN
  logic [X_W-1:0] clr_x_q, clr_x_d;
  logic [Y_W-1:0] clr_y_q, clr_y_d;
`endif

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i ({req_p2, req_p1}),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    bx_d       = bx_q;
    by_d       = by_q;
    col_d      = col_q;
    gnt_d      = gnt_q;
    arb_en     = 1'b0;
    ack_p1     = 1'b0;
    ack_p2     = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    busy       = (state_q != IDLE);
`ifdef SCREEN_CLEAR_EN
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          arb_en  = 1'b1;
          gnt_d   = arb_gnt;
          bx_d    = (arb_gnt == P1) ? x_p1 : x_p2;
          by_d    = (arb_gnt == P1) ? y_p1 : y_p2;
          col_d   = (arb_gnt == P1) ? colour_p1 : colour_p2;
          cx_d    = '0;
          cy_d    = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // Sums wrap at the coordinate width; no clipping at screen edges.
        vga_plot   = 1'b1;
        vga_x      = bx_q + X_W'(cx_q);
        vga_y      = by_q + Y_W'(cy_q);
        vga_colour = col_q;
        if (cx_q == CXW'(BOX_W - 1)) begin
          cx_d = '0;
          if (cy_q == CYW'(BOX_H - 1)) begin
            cy_d    = '0;
            state_d = ACK;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      ACK: begin
        ack_p1  = (gnt_q == P1);
        ack_p2  = (gnt_q == P2);
        state_d = IDLE;
      end
      CLEAR: begin
`ifdef SCREEN_CLEAR_EN
        vga_plot = 1'b1;
        vga_x    = clr_x_q;
        vga_y    = clr_y_q;
        if (clr_x_q == X_W'(SCREEN_W - 1)) begin
          clr_x_d = '0;
          if (clr_y_q == Y_W'(SCREEN_H - 1)) begin
            clr_y_d = '0;
            state_d = IDLE;
          end else begin
            clr_y_d = clr_y_q + 1'b1;
          end
        end else begin
          clr_x_d = clr_x_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SCREEN_CLEAR_EN
      state_q <= CLEAR;
      clr_x_q <= '0;
      clr_y_q <= '0;
`else
      state_q <= IDLE;
`endif
      cx_q    <= '0;
      cy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      col_q   <= '0;
      gnt_q   <= P2;
    end else begin
`ifdef SCREEN_CLEAR_EN
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
`endif
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      col_q   <= col_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: vector table of single boxes plus multi-cycle sequences.
// Outputs sampled on the falling edge; inputs changed on the falling edge.
module tb_plot_arbiter;

  logic       clk;
  logic       reset;
  logic       req_p1, req_p2;
  logic [7:0] x_p1, x_p2;
  logic [6:0] y_p1, y_p2;
  logic [2:0] colour_p1, colour_p2;
  logic       ack_p1, ack_p2, busy, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int n_chk  = 0;
  int n_pass = 0;

  plot_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_p1     (req_p1),
    .x_p1       (x_p1),
    .y_p1       (y_p1),
    .colour_p1  (colour_p1),
    .req_p2     (req_p2),
    .x_p2       (x_p2),
    .y_p2       (y_p2),
    .colour_p2  (colour_p2),
    .ack_p1     (ack_p1),
    .ack_p2     (ack_p2),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r1, r2;
    int   x1, y1, c1;
    int   x2, y2, c2;
    logic ep;
    int   ex, ey, ec;
    int   mode;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_ctl"}, {busy, vga_plot, ack_p1, ack_p2}, 0);
    chk({name, "_xyc"}, int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
  endtask

  // lead = falling edges until the first pixel; lead-1 of them are IDLE gap cycles.
  // mode 1: scramble both players' coordinates after pixel 0; mode 2: drop req after pixel 3.
  task automatic draw_box(input logic p, input int bx, input int by, input int bc,
                          input int lead, input int mode);
    for (int g = 0; g < lead - 1; g++) begin
      @(negedge clk);
      idle_chk("gap");
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("px_x", vga_x, (bx + i) % 256);
        chk("px_y", vga_y, (by + j) % 128);
        chk("px_colour", vga_colour, bc);
        chk("px_ctl", {vga_plot, busy, ack_p1, ack_p2}, 4'b1100);
        if (mode == 1 && i == 0 && j == 0) begin
          x_p1 = x_p1 + 8'd37;  y_p1 = y_p1 + 7'd11;  colour_p1 = ~colour_p1;
          x_p2 = x_p2 + 8'd53;  y_p2 = y_p2 + 7'd29;  colour_p2 = ~colour_p2;
        end
        if (mode == 2 && i == 3 && j == 0) begin
          if (p == 1'b0) req_p1 = 1'b0;
          else req_p2 = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("ack", {ack_p1, ack_p2, vga_plot, busy}, (p == 1'b0) ? 4'b1001 : 4'b0101);
    chk("ack_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_p1(input int x, input int y, input int c);
    x_p1 = 8'(x); y_p1 = 7'(y); colour_p1 = 3'(c);
  endtask

  task automatic set_p2(input int x, input int y, input int c);
    x_p2 = 8'(x); y_p2 = 7'(y); colour_p2 = 3'(c);
  endtask

  initial begin
    reset = 1'b1;
    req_p1 = 1'b0; req_p2 = 1'b0;
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);

    vt[0] = '{1'b1, 1'b0, 10, 20, 3, 0, 0, 0, 1'b0, 10, 20, 3, 0};
    vt[1] = '{1'b0, 1'b1, 0, 0, 0, 30, 40, 5, 1'b1, 30, 40, 5, 0};
    vt[2] = '{1'b1, 1'b0, 254, 126, 6, 0, 0, 0, 1'b0, 254, 126, 6, 0};
    vt[3] = '{1'b1, 1'b1, 1, 2, 1, 100, 50, 7, 1'b1, 100, 50, 7, 1};
    vt[4] = '{1'b1, 1'b1, 5, 6, 2, 7, 8, 4, 1'b0, 5, 6, 2, 0};
    vt[5] = '{1'b1, 1'b0, 0, 0, 7, 200, 9, 1, 1'b0, 0, 0, 7, 0};
    vt[6] = '{1'b1, 1'b1, 9, 9, 1, 252, 125, 2, 1'b1, 252, 125, 2, 0};

    do_reset();

`ifdef SCREEN_CLEAR_EN
    begin
      int errs;
      errs = 0;
      set_p1(10, 20, 3);
      req_p1 = 1'b1;
      for (int i = 0; i < 19200; i++) begin
        if (!(vga_plot && busy && !ack_p1 && !ack_p2 && vga_colour == 3'd0 &&
              int'(vga_x) == i % 160 && int'(vga_y) == i / 160)) errs++;
        @(negedge clk);
      end
      chk("clear_sweep_errors", errs, 0);
      idle_chk("clear_done");
      draw_box(1'b0, 10, 20, 3, 1, 0);
      req_p1 = 1'b0;
      @(negedge clk);
      idle_chk("clear_box_idle");
    end
`else
    idle_chk("reset");
    repeat (3) begin
      @(negedge clk);
      idle_chk("noreq");
    end

    // Simultaneous requests right after reset: P1 first, P2 acked 18 cycles later.
    set_p1(10, 20, 3);
    set_p2(30, 40, 5);
    req_p1 = 1'b1; req_p2 = 1'b1;
    draw_box(1'b0, 10, 20, 3, 1, 0);
    req_p1 = 1'b0;
    draw_box(1'b1, 30, 40, 5, 2, 0);
    req_p2 = 1'b0;
    @(negedge clk);
    idle_chk("both_idle");

    for (int k = 0; k < 7; k++) begin
      set_p1(vt[k].x1, vt[k].y1, vt[k].c1);
      set_p2(vt[k].x2, vt[k].y2, vt[k].c2);
      req_p1 = vt[k].r1; req_p2 = vt[k].r2;
      draw_box(vt[k].ep, vt[k].ex, vt[k].ey, vt[k].ec, 1, vt[k].mode);
      req_p1 = 1'b0; req_p2 = 1'b0;
      @(negedge clk);
      idle_chk("vec_idle");
    end

    // Both held for four boxes: strict alternation, one idle cycle between boxes.
    set_p1(40, 60, 4);
    set_p2(80, 90, 6);
    req_p1 = 1'b1; req_p2 = 1'b1;
    draw_box(1'b0, 40, 60, 4, 1, 0);
    draw_box(1'b1, 80, 90, 6, 2, 0);
    draw_box(1'b0, 40, 60, 4, 2, 0);
    draw_box(1'b1, 80, 90, 6, 2, 0);
    req_p1 = 1'b0; req_p2 = 1'b0;
    @(negedge clk);
    idle_chk("held_idle");

    // Request withdrawn mid-draw still completes and acks once.
    set_p1(70, 33, 5);
    req_p1 = 1'b1;
    draw_box(1'b0, 70, 33, 5, 1, 2);
    @(negedge clk);
    idle_chk("drop_idle");
    @(negedge clk);
    idle_chk("drop_idle2");

    // Reset on the fifth pixel of a P2 box.
    set_p2(50, 60, 7);
    req_p2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_px5_x", vga_x, 50);
    chk("rst_px5_y", vga_y, 61);
    chk("rst_px5_plot", vga_plot, 1);
    reset = 1'b1;
    @(negedge clk);
    idle_chk("rst_mid");
    reset = 1'b0;
    req_p2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      idle_chk("rst_after");
    end
    set_p1(12, 14, 1);
    req_p1 = 1'b1; req_p2 = 1'b1;
    draw_box(1'b0, 12, 14, 1, 1, 0);
    req_p1 = 1'b0; req_p2 = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Shares the single VGA plot port between the two player controllers in the race game. Each player requests a box draw at a base coordinate and colour. The arbiter grants requesters round-robin, sweeps the BOX_W x BOX_H pixels of the box one pixel per cycle, then acknowledges the granted player. It sits between the per-player control/datapath pairs and the VGA adapter.

Parameters:
BOX_W, 4, box width in pixels (power of two not required, >=1)
BOX_H, 4, box height in pixels (>=1)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
SCREEN_W, 160, screen width used by clear sweep
SCREEN_H, 120, screen height used by clear sweep

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
req_p1  in  1  player 1 draw request, level
x_p1  in  X_W  player 1 box base x
y_p1  in  Y_W  player 1 box base y
colour_p1  in  C_W  player 1 box colour
req_p2, x_p2, y_p2, colour_p2  in  1/X_W/Y_W/C_W  same for player 2
ack_p1  out  1  one-cycle pulse: player 1 box fully drawn
ack_p2  out  1  one-cycle pulse: player 2 box fully drawn
busy  out  1  high whenever state != IDLE
vga_x  out  X_W  pixel x to VGA adapter
vga_y  out  Y_W  pixel y to VGA adapter
vga_colour  out  C_W  pixel colour
vga_plot  out  1  write-enable for the current pixel

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, last_grant=P2 (so P1 wins the first tie), cx=cy=0, all outputs 0.
- States: IDLE, DRAW, ACK (+CLEAR with feature).
- IDLE:
  - If either req is high, grant. With both high, grant the player != last_grant.
  - Latch base x/y/colour of the granted player, set last_grant, go DRAW.
  - No req: stay.
- DRAW:
  - vga_plot=1, vga_x=base_x+cx, vga_y=base_y+cy, vga_colour=latched colour.
  - cx counts 0..BOX_W-1, then wraps to 0 and cy increments.
  - After pixel (BOX_W-1, BOX_H-1): go ACK, clear cx/cy.
- ACK: the granted player's ack=1 for exactly one cycle (Moore output), vga_plot=0, then IDLE.
- Handshake:
  - Requester holds req and coordinates until it samples ack, then drops req.
  - Coordinates are latched at grant; changes during DRAW are ignored.
  - req dropped mid-draw: the draw still completes and ack still pulses.
- Latency: req seen in IDLE at cycle 0 -> pixels cycles 1..BOX_W*BOX_H -> ack at cycle BOX_W*BOX_H+1 -> IDLE next cycle. Throughput is one box per BOX_W*BOX_H+2 cycles.
- Width rule: coordinate sums are truncated to X_W/Y_W (modulo wrap, no clipping).
- Reset mid-DRAW: the next cycle is IDLE, vga_plot=0, no ack, last_grant returns to P2.
- A requester still asserting req in IDLE after ack is treated as a new request. Round-robin then favours the other player if both are requesting.
- Outputs vga_x/vga_y/vga_colour are 0 outside DRAW/CLEAR.

Optional Feature:
SCREEN_CLEAR_EN:
- Defined: reset enters CLEAR. The block sweeps all SCREEN_W*SCREEN_H pixels row-major with colour 0 and vga_plot=1, busy=1, requests ignored. It then goes to IDLE; no ack is issued.
- Undefined: reset goes directly to IDLE and no CLEAR state or sweep counters exist.

Decomposition:
- Shared package plot_pkg:
  - state enum (IDLE, DRAW, ACK, CLEAR)
  - player id constants P1=0, P2=1
  - default BOX_W/BOX_H/X_W/Y_W/C_W/SCREEN_W/SCREEN_H
- Sub-module rr_arbiter2: 2-way round-robin grant with last_grant register and update-on-grant enable.
- Pixel counters and FSM live in plot_arbiter.

Test Plan:
- P1 only, req with (10,20), colour 3:
  - 16 plot cycles covering x10-13/y20-23, row-major, colour 3.
  - ack_p1 pulses at cycle 17; ack_p2 stays 0.
- Both req together right after reset: P1 box is drawn and acked first. P2 is granted in the IDLE after that and acked 18 cycles after ack_p1.
- Both held continuously for 4 boxes: grants alternate P1,P2,P1,P2 and busy drops for exactly one cycle between boxes.
- Reset asserted on the 5th DRAW pixel of a P2 box: vga_plot=0 the next cycle, no ack_p2. A subsequent simultaneous req grants P1.
- Wrap case, P1 at x=254, y=126: x sequence 254,255,0,1 and y sequence 126,127,0,1.
- SCREEN_CLEAR_EN defined:
  - After reset, exactly 19200 plot cycles occur with colour 0, x 0..159, y 0..119.
  - A req_p1 held throughout is granted only after the sweep.
